// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues one instruction
// memory request at a time, holds the returned word until the IF-ID register
// captures it, applies branch/jump redirects and throws away memory responses
// that belong to a fetch made obsolete by a redirect. When no real instruction
// is held, it presents a bubble (NOP_INSTR, PC_4_out = 0, valid_out = 0).
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   stall_n        1 = IF-ID captures this cycle, 0 = IF-ID holds
//   redirect_in    branch/jump taken, load redirect_pc_in into the PC
//   redirect_pc_in redirect target address
//   imem_req_out   instruction memory request valid
//   imem_addr_out  request address, stable while imem_req_out is high
//   imem_ack_in    one-cycle response strobe from instruction memory
//   imem_rdata_in  response data, valid with imem_ack_in
//   PC_4_out       address of the held instruction + 4 (to IF-ID PC_4_in)
//   instr_out      held instruction (to IF-ID instr_in)
//   valid_out      PC_4_out / instr_out carry a real instruction
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_n,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] PC_4_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    // FETCH   : request outstanding for pc (pc == req_addr)
    // READY   : word held in ibuf, waiting for IF-ID to take it
    // DISCARD : request outstanding for an address made stale by a redirect
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        READY   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] req_addr_nxt;
    logic [31:0] ibuf;
    logic [31:0] ibuf_nxt;

    // State register. Reset wins over everything, so an in-flight request
    // is simply forgotten and fetching restarts from RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            ibuf     <= NOP_INSTR;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            ibuf     <= ibuf_nxt;
        end
    end

    // Next-state logic. Everything holds by default; each state only names
    // the registers it changes.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        ibuf_nxt     = ibuf;

        case (state)
            FETCH: begin
                if (redirect_in) begin
                    pc_nxt = redirect_pc_in;
                    if (imem_ack_in) begin
                        // The response just arrived, so the bus is free and
                        // the new target can be requested straight away.
                        req_addr_nxt = redirect_pc_in;
                    end else begin
                        // The old request is still in flight; keep its
                        // address on the bus until its ack is swallowed.
                        state_nxt = DISCARD;
                    end
                end else if (imem_ack_in) begin
                    ibuf_nxt  = imem_rdata_in;
                    state_nxt = READY;
                end
            end

            READY: begin
                if (redirect_in) begin
                    // The hazard unit flushes IF-ID this same cycle, so the
                    // held word is dropped rather than handed over.
                    pc_nxt       = redirect_pc_in;
                    req_addr_nxt = redirect_pc_in;
                    state_nxt    = FETCH;
                end else if (stall_n) begin
                    pc_nxt       = pc + 32'd4;
                    req_addr_nxt = pc + 32'd4;
                    state_nxt    = FETCH;
                end
            end

            DISCARD: begin
                if (redirect_in) begin
                    pc_nxt = redirect_pc_in;
                end
                if (imem_ack_in) begin
                    req_addr_nxt = redirect_in ? redirect_pc_in : pc;
                    state_nxt    = FETCH;
                end
            end

            default: begin
                state_nxt    = FETCH;
                pc_nxt       = RESET_PC;
                req_addr_nxt = RESET_PC;
                ibuf_nxt     = NOP_INSTR;
            end
        endcase
    end

    // Memory side: a request is pending whenever no word is being held.
    assign imem_req_out  = (state == FETCH) || (state == DISCARD);
    assign imem_addr_out = req_addr;

    // Pipeline side: real instruction only in READY, otherwise a bubble.
    assign valid_out = (state == READY);
    assign instr_out = (state == READY) ? ibuf : NOP_INSTR;
    assign PC_4_out  = (state == READY) ? (req_addr + 32'd4) : 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. The stimulus process pushes the expected
// request addresses and the expected IF-ID captures into two queues; a monitor
// on the falling edge pops and compares whenever the DUT completes a memory
// handshake or hands an instruction to IF-ID. Point checks of the full output
// set are made at specific cycles.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_n;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] PC_4_out;
    logic [31:0] instr_out;
    logic        valid_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_out_q[$];

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_n       (stall_n),
        .redirect_in   (redirect_in),
        .redirect_pc_in(redirect_pc_in),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_ack_in   (imem_ack_in),
        .imem_rdata_in (imem_rdata_in),
        .PC_4_out      (PC_4_out),
        .instr_out     (instr_out),
        .valid_out     (valid_out)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs just after the rising edge, then stop on the
    // following falling edge so the caller can inspect settled outputs.
    task automatic applyStimulus(input logic        r,
                                 input logic        stl,
                                 input logic        redir,
                                 input logic [31:0] rpc,
                                 input logic        ack,
                                 input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst            = r;
        stall_n        = stl;
        redirect_in    = redir;
        redirect_pc_in = rpc;
        imem_ack_in    = ack;
        imem_rdata_in  = rdata;
        @(negedge clk);
    endtask

    // Compare the whole output bundle against hand-computed values.
    task automatic checkOutput(input string       name,
                               input logic        e_req,
                               input logic [31:0] e_addr,
                               input logic        e_valid,
                               input logic [31:0] e_pc4,
                               input logic [31:0] e_instr);
        vectors++;
        if ({imem_req_out, imem_addr_out, valid_out, PC_4_out, instr_out} !==
            {e_req, e_addr, e_valid, e_pc4, e_instr}) begin
            miscompares++;
            $display("[TB] FAIL %s: got req=%b addr=%h valid=%b pc4=%h instr=%h, expected req=%b addr=%h valid=%b pc4=%h instr=%h",
                     name, imem_req_out, imem_addr_out, valid_out, PC_4_out, instr_out,
                     e_req, e_addr, e_valid, e_pc4, e_instr);
        end
    endtask

    // Monitor: scoreboard for handshakes and IF-ID captures, plus a bubble
    // check on every cycle without a valid instruction.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (imem_req_out && imem_ack_in) begin
                vectors++;
                if (exp_req_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL req_addr: got handshake at addr=%h, expected no handshake", imem_addr_out);
                end else begin
                    logic [31:0] e_addr;
                    e_addr = exp_req_q.pop_front();
                    if (imem_addr_out !== e_addr) begin
                        miscompares++;
                        $display("[TB] FAIL req_addr: got addr=%h, expected addr=%h", imem_addr_out, e_addr);
                    end
                end
            end
            if (valid_out && stall_n && !redirect_in) begin
                vectors++;
                if (exp_out_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL capture: got pc4=%h instr=%h, expected no capture", PC_4_out, instr_out);
                end else begin
                    logic [63:0] e_out;
                    e_out = exp_out_q.pop_front();
                    if ({PC_4_out, instr_out} !== e_out) begin
                        miscompares++;
                        $display("[TB] FAIL capture: got pc4=%h instr=%h, expected pc4=%h instr=%h",
                                 PC_4_out, instr_out, e_out[63:32], e_out[31:0]);
                    end
                end
            end
            if (valid_out !== 1'b1) begin
                vectors++;
                if ({PC_4_out, instr_out} !== 64'h0) begin
                    miscompares++;
                    $display("[TB] FAIL bubble: got pc4=%h instr=%h, expected pc4=00000000 instr=00000000",
                             PC_4_out, instr_out);
                end
            end
        end
    end

    // Directed sequence; the comment on each step states the DUT state
    // expected after the following rising edge.
    initial begin
        rst            = 1'b1;
        stall_n        = 1'b1;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        imem_ack_in    = 1'b0;
        imem_rdata_in  = 32'h0;

        // Reset for two edges
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // First cycle after release
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset_state", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Ack the fetch of 0x0 -> READY with 0x2000_0001
        exp_req_q.push_back(32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2000_0001);

        // Stall three cycles: outputs frozen, no request; a stray ack is ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("stall_hold_1", 1'b0, 32'h0, 1'b1, 32'h4, 32'h2000_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
        checkOutput("stall_hold_2", 1'b0, 32'h0, 1'b1, 32'h4, 32'h2000_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("stall_hold_3", 1'b0, 32'h0, 1'b1, 32'h4, 32'h2000_0001);

        // Release stall: IF-ID takes (0x4, 0x2000_0001) -> FETCH 0x4
        exp_out_q.push_back({32'h0000_0004, 32'h2000_0001});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Ack fetch of 0x4 in the same cycle the request appears
        exp_req_q.push_back(32'h0000_0004);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2000_0002);

        // IF-ID takes (0x8, 0x2000_0002) -> FETCH 0x8
        exp_out_q.push_back({32'h0000_0008, 32'h2000_0002});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect to 0x100 while fetching 0x8 without ack -> DISCARD
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("discard_wait", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);

        // Stale ack for 0x8 carrying 0xDEAD_BEEF is swallowed -> FETCH 0x100
        exp_req_q.push_back(32'h0000_0008);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("after_discard", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

        // Fetch 0x100 -> READY with 0x3000_0001
        exp_req_q.push_back(32'h0000_0100);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0001);

        // Redirect to 0x200 in READY with stall_n=1: held word dropped
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        checkOutput("ready_before_redirect", 1'b0, 32'h100, 1'b1, 32'h104, 32'h3000_0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("ready_redirect", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);

        // Fetch 0x200 and hand it over -> FETCH 0x204
        exp_req_q.push_back(32'h0000_0200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0002);
        exp_out_q.push_back({32'h0000_0204, 32'h3000_0002});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect 0x280 in FETCH -> DISCARD; then 0x300, then 0x400 with ack
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0280, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        checkOutput("discard_redirect_1", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
        exp_req_q.push_back(32'h0000_0204);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'hBADC_0DE0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("discard_latest_wins", 1'b1, 32'h400, 1'b0, 32'h0, 32'h0);

        // Fetch 0x400 and hand it over -> FETCH 0x404
        exp_req_q.push_back(32'h0000_0400);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4000_0001);
        exp_out_q.push_back({32'h0000_0404, 32'h4000_0001});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Request 0x404 in flight, then reset; its ack lands during reset
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("mid_request", 1'b1, 32'h404, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset_mid_request_1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset_mid_request_2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Fresh fetch of 0x0 after reset
        exp_req_q.push_back(32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5000_0001);
        exp_out_q.push_back({32'h0000_0004, 32'h5000_0001});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect to 0xFFFF_FFFC in FETCH with a same-cycle ack: data dropped,
        // new target requested immediately
        exp_req_q.push_back(32'h0000_0004);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1111_1111);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("fetch_redirect_ack", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

        // Top-of-memory word: PC_4_out wraps to 0, next fetch wraps to 0
        exp_req_q.push_back(32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6000_0001);
        exp_out_q.push_back({32'h0000_0000, 32'h6000_0001});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("pc4_wrap", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h6000_0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("pc_wrap", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Everything expected must have been consumed by the monitor
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        vectors++;
        if (exp_req_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL req_queue_drain: got %0d pending, expected 0", exp_req_q.size());
        end
        vectors++;
        if (exp_out_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL out_queue_drain: got %0d pending, expected 0", exp_out_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
